// File: rtl/bp_be_accel_pkg.sv
// Shared types for the accelerator writeback path.
//   bp_be_accel_wb_state_e : scheduler state (run / drain)
//   bp_be_accel_win_s      : per-destination address window {base, len, offset}
//   num_accel_dest_gp      : number of result destinations
//   paddr_width_gp         : physical address width the window struct is sized for;
//                            the scheduler's paddr_width_p must equal it.
package bp_be_accel_pkg;

  localparam int num_accel_dest_gp = 2;
  localparam int paddr_width_gp    = 40;

  typedef enum logic {
    e_run   = 1'b0,
    e_drain = 1'b1
  } bp_be_accel_wb_state_e;

  typedef struct packed {
    logic [paddr_width_gp-1:0] base;
    logic [paddr_width_gp-1:0] len;     // 0 = linear, no wrap
    logic [paddr_width_gp-1:0] offset;
  } bp_be_accel_win_s;

endpackage

// File: rtl/bp_be_accel_wb_credit.sv
// Up/down credit counter bounding outstanding writes.
// Ports:
//   clk_i, reset_n_i : clock, async active-low reset (counter resets full)
//   take_i           : a credit is consumed this cycle (never asserted when empty)
//   ack_i            : a credit is returned this cycle
//   full_o           : all credits free
//   empty_o          : no credits left
//   err_o            : sticky, an ack arrived with every credit already free
module bp_be_accel_wb_credit #(
  parameter int credits_p = 8
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic take_i,
  input  logic ack_i,
  output logic full_o,
  output logic empty_o,
  output logic err_o
);

  localparam int                cnt_w_lp = $clog2(credits_p + 1);
  localparam logic [cnt_w_lp-1:0] max_lp = cnt_w_lp'(credits_p);

  logic [cnt_w_lp-1:0] cnt_q;
  logic                spurious;

  assign full_o   = (cnt_q == max_lp);
  assign empty_o  = (cnt_q == '0);
  // A simultaneous take absorbs the ack, so only a lone ack on a full counter is bogus.
  assign spurious = ack_i & ~take_i & full_o;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q <= max_lp;
      err_o <= 1'b0;
    end else begin
      if (take_i & ~ack_i)                cnt_q <= cnt_q - 1'b1;
      else if (ack_i & ~take_i & ~full_o) cnt_q <= cnt_q + 1'b1;
      if (spurious) err_o <= 1'b1;
    end
  end

endmodule

// File: rtl/bp_be_accel_wb_sched.sv
// Writeback scheduler for the accelerator result path.
// Takes tagged result beats, assigns each a physical address from a per-destination
// base/len window (wrapping when len != 0), and holds {addr, data} in a one-entry
// slot toward the mem_fwd pump. Outstanding writes are bounded by credits returned
// through mem_rev acks; fence_i drains everything and answers with fence_done_o.
// Ports:
//   clk_i, reset_n_i                       : clock, async active-low reset
//   cfg_v_i/cfg_dest_i/cfg_base_i/cfg_len_i : window programming (blocks beats that cycle)
//   beat_v_i/beat_dest_i/beat_data_i        : result beat in, beat_ready_and_o handshake
//   wr_v_o/wr_addr_o/wr_data_o              : write request out, wr_ready_and_i handshake
//   ack_v_i                                 : one write ack per cycle
//   fence_i / fence_done_o                  : drain request / completion pulse
//   rd_dest_i / rd_addr_o                   : combinational next-address readback
//   wrap_o                                  : per-destination wrap pulse
//   idle_o, err_o                           : nothing pending / sticky spurious ack
// Optional: define BP_BE_ACCEL_WB_PERF_EN to add saturating perf_beats_o (write
// handshakes) and perf_stall_o (cycles a valid beat is refused).
module bp_be_accel_wb_sched
  import bp_be_accel_pkg::*;
#(
  parameter int paddr_width_p = paddr_width_gp,
  parameter int data_width_p  = 128,
  parameter int beat_bytes_p  = 16,
  parameter int credits_p     = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     cfg_v_i,
  input  logic                     cfg_dest_i,
  input  logic [paddr_width_p-1:0] cfg_base_i,
  input  logic [paddr_width_p-1:0] cfg_len_i,
  input  logic                     beat_v_i,
  input  logic                     beat_dest_i,
  input  logic [data_width_p-1:0]  beat_data_i,
  output logic                     beat_ready_and_o,
  output logic                     wr_v_o,
  output logic [paddr_width_p-1:0] wr_addr_o,
  output logic [data_width_p-1:0]  wr_data_o,
  input  logic                     wr_ready_and_i,
  input  logic                     ack_v_i,
  input  logic                     fence_i,
  output logic                     fence_done_o,
  input  logic                     rd_dest_i,
  output logic [paddr_width_p-1:0] rd_addr_o,
  output logic [1:0]               wrap_o,
  output logic                     idle_o,
  output logic                     err_o
`ifdef BP_BE_ACCEL_WB_PERF_EN
 ,output logic [31:0]              perf_beats_o
 ,output logic [31:0]              perf_stall_o
`endif
);

  localparam logic [paddr_width_p-1:0] beat_inc_lp = paddr_width_p'(beat_bytes_p);

  bp_be_accel_wb_state_e state_q, state_n;

  logic                     slot_v_q;
  logic [paddr_width_p-1:0] slot_addr_q;
  logic [data_width_p-1:0]  slot_data_q;
  logic                     fence_done_q;
  logic                     accept, wr_hs, drained;
  logic                     cr_full, cr_empty;
  logic [paddr_width_p-1:0] addr [num_accel_dest_gp];

  assign accept  = beat_v_i & beat_ready_and_o;
  assign wr_hs   = slot_v_q & wr_ready_and_i;
  assign drained = ~slot_v_q & cr_full;

  // ---------------- credits ----------------
  bp_be_accel_wb_credit #(.credits_p(credits_p)) credit (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .take_i   (accept),
    .ack_i    (ack_v_i),
    .full_o   (cr_full),
    .empty_o  (cr_empty),
    .err_o    (err_o)
  );

  // ---------------- FSM ----------------
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= e_run;
      fence_done_q <= 1'b0;
    end else begin
      state_q      <= state_n;
      // Pulse lands on the same edge that returns us to e_run.
      fence_done_q <= (state_q == e_drain) & drained;
    end
  end

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      e_run:   if (fence_i) state_n = e_drain;
      e_drain: if (drained) state_n = e_run;
      default: state_n = e_run;
    endcase
  end

  always_comb begin
    // Slot may refill in the cycle it drains, giving 1 beat/cycle.
    beat_ready_and_o = (state_q == e_run) & ~cfg_v_i & ~cr_empty
                     & (~slot_v_q | wr_ready_and_i);
    fence_done_o     = fence_done_q;
    idle_o           = drained;
  end

  // ---------------- per-destination windows ----------------
  for (genvar d = 0; d < num_accel_dest_gp; d++) begin : g_win
    bp_be_accel_win_s         win_q;
    logic                     wrap_q;
    logic [paddr_width_p-1:0] off_n;
    logic                     wrap_hit, cfg_sel, beat_sel;

    assign cfg_sel  = cfg_v_i & (cfg_dest_i == 1'(d));
    assign beat_sel = accept & (beat_dest_i == 1'(d));
    assign off_n    = win_q.offset + beat_inc_lp;
    assign wrap_hit = (win_q.len != '0) & (off_n >= win_q.len);
    assign addr[d]  = win_q.base + win_q.offset;
    assign wrap_o[d] = wrap_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        win_q  <= '0;
        wrap_q <= 1'b0;
      end else begin
        wrap_q <= 1'b0;
        if (cfg_sel) begin
          win_q.base   <= cfg_base_i;
          win_q.len    <= cfg_len_i;
          win_q.offset <= '0;
        end else if (beat_sel) begin
          win_q.offset <= wrap_hit ? '0 : off_n;
          wrap_q       <= wrap_hit;
        end
      end
    end
  end

  assign rd_addr_o = addr[rd_dest_i];

  // ---------------- output slot ----------------
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      slot_v_q    <= 1'b0;
      slot_addr_q <= '0;
      slot_data_q <= '0;
    end else if (accept) begin
      slot_v_q    <= 1'b1;
      slot_addr_q <= addr[beat_dest_i];
      slot_data_q <= beat_data_i;
    end else if (wr_hs) begin
      slot_v_q    <= 1'b0;
    end
  end

  assign wr_v_o    = slot_v_q;
  assign wr_addr_o = slot_addr_q;
  assign wr_data_o = slot_data_q;

`ifdef BP_BE_ACCEL_WB_PERF_EN
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      perf_beats_o <= '0;
      perf_stall_o <= '0;
    end else begin
      if (wr_hs && !(&perf_beats_o))                          perf_beats_o <= perf_beats_o + 1'b1;
      if (beat_v_i && !beat_ready_and_o && !(&perf_stall_o))  perf_stall_o <= perf_stall_o + 1'b1;
    end
  end
`endif

endmodule

// File: doc/bp_be_accel_wb_sched.md
Name: bp_be_accel_wb_sched

Overview:
- Writeback scheduler for the accelerator result path.
- Accepts tagged result beats (dest 0/1) from the result FIFO and assigns each a physical write address from per-destination base/length windows, with wrap-around.
- Registers address and data in a 1-entry output slot toward the mem_fwd stream pump.
- Bounds outstanding uncached writes with a credit counter that is replenished by mem_rev acks, and supports a fence/drain handshake.

Parameters:
- paddr_width_p, 40, physical address width.
- data_width_p, 128, beat width in bits (bedrock fill width).
- beat_bytes_p, 16, address increment per beat (data_width_p/8).
- credits_p, 8, maximum outstanding writes; must be at least 1.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous active-low reset.
- cfg_v_i  in  1  window config write strobe.
- cfg_dest_i  in  1  destination being configured.
- cfg_base_i  in  paddr_width_p  window base; must be beat_bytes_p aligned.
- cfg_len_i  in  paddr_width_p  window length in bytes; 0 means linear, no wrap.
- beat_v_i  in  1  result beat valid.
- beat_dest_i  in  1  beat destination buffer.
- beat_data_i  in  data_width_p  beat payload.
- beat_ready_and_o  out  1  beat accepted when high together with beat_v_i.
- wr_v_o  out  1  write request valid.
- wr_addr_o  out  paddr_width_p  write address.
- wr_data_o  out  data_width_p  write data.
- wr_ready_and_i  in  1  pump accepts the write.
- ack_v_i  in  1  one write ack (mem_rev beat) per cycle.
- fence_i  in  1  drain request pulse.
- fence_done_o  out  1  one-cycle pulse when drain completes.
- rd_dest_i  in  1  readback select.
- rd_addr_o  out  paddr_width_p  next address for rd_dest_i (combinational).
- wrap_o  out  2  per-destination one-cycle pulse on window wrap.
- idle_o  out  1  no pending or outstanding writes.
- err_o  out  1  sticky: ack received with all credits free.

Behaviour:
- Reset (async assert; release is synchronous to clk_i):
  - state = e_run; credits = credits_p; base/len/offset of both destinations = 0; output slot empty.
  - Outputs: wr_v_o=0, wrap_o=0, fence_done_o=0, err_o=0, idle_o=1. beat_ready_and_o=1 once reset deasserts.
- States:
  - e_run: accept beats.
  - e_drain: refuse beats; when output slot is empty and credits==credits_p, go to e_run and pulse fence_done_o that same edge.
  - fence_i in e_run -> e_drain. fence_i in e_drain is ignored.
  - If already drained when fence_i arrives, the pulse comes 1 cycle later.
- beat_ready_and_o = (state==e_run) & ~cfg_v_i & credits>0 & (slot empty | wr_ready_and_i).
  - Slot may be refilled in the same cycle it drains: full throughput is 1 beat/cycle.
- On beat accept:
  - Slot loads {base[d]+offset[d], data}; credit is consumed at accept time.
  - Latency beat -> wr_v_o is 1 cycle.
- Slot valid is held until wr_ready_and_i; wr_addr_o and wr_data_o are stable while wr_v_o is high.
- Offset update: off_n = offset+beat_bytes_p.
  - If len!=0 and off_n>=len: offset=0 and wrap_o[d] pulses the next cycle.
  - Otherwise offset=off_n. Arithmetic is modulo 2^paddr_width_p.
- Credits:
  - -1 on beat accept, +1 on ack_v_i; both in the same cycle leaves credits unchanged.
  - ack_v_i with credits==credits_p and no simultaneous accept: ignored, err_o set until reset.
- cfg_v_i: loads base/len for cfg_dest_i and zeroes its offset. Beats are blocked that cycle; the slot contents are unaffected.
- idle_o = slot empty & credits==credits_p.
- rd_addr_o = base[rd_dest_i]+offset[rd_dest_i].

Optional Feature:
- Macro BP_BE_ACCEL_WB_PERF_EN.
- Defined: adds ports perf_beats_o[31:0] and perf_stall_o[31:0].
  - perf_beats_o counts wr handshakes.
  - perf_stall_o counts cycles with beat_v_i & ~beat_ready_and_o.
  - Both saturate at all-ones and reset to 0.
- Undefined: ports absent, no counter logic.

Decomposition:
- Package bp_be_accel_pkg:
  - bp_be_accel_wb_state_e {e_run, e_drain}.
  - bp_be_accel_win_s {base, len, offset}.
  - Constant num_accel_dest_gp = 2.
- Sub-module bp_be_accel_wb_credit: up/down credit counter with full/empty flags and spurious-ack error detection.

Test Plan:
- Base0=0x8000_0000, len0=0; 4 beats dest0, ready always high, acks 2 cycles later -> addrs 0x8000_0000/10/20/30 back-to-back; credits return to 8; idle_o=1.
- len1=0x30, base1=0x1000; 4 beats dest1 -> addrs 0x1000, 0x1010, 0x1020, 0x1000; wrap_o[1] pulses once after the 3rd accept.
- credits_p=8, no acks, wr_ready_and_i=1; 10 beats -> exactly 8 accepted, then beat_ready_and_o=0; one ack_v_i -> 9th accepted the next cycle.
- wr_ready_and_i=0 for 5 cycles with the slot full -> wr_addr_o/wr_data_o stable, beat_ready_and_o=0; release -> handshake and refill in the same cycle.
- fence_i with 3 outstanding -> beats refused; after the 3rd ack, fence_done_o pulses exactly once; ack in the same cycle as an accept leaves credits unchanged; extra ack when idle -> err_o=1.
- Assert reset_n_i mid-stream with slot full -> wr_v_o drops immediately (async); after release, credits=8, offsets 0, first beat goes to base+0.
